sample_fifo: RTL and testbench

//  Single-clock, parametrised sample FIFO between the MIDI/synth voice engine (producer) and the

---
 rtl/sample_fifo_pkg.sv | 18 +
 rtl/sample_fifo_mem.sv | 30 +++
 rtl/sample_fifo.sv | 128 ++++++++++++
 tb/tb_sample_fifo.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/sample_fifo_pkg.sv
// Shared types and helpers for the sample FIFO between the voice engine and the codec serialiser.
package sample_fifo_pkg;

  // LEVEL must represent 0..DEPTH inclusive, so it needs one bit more than the address.
  function automatic int level_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
    logic overflow;
    logic underflow;
  } fifo_status_t;

endpackage

// File: rtl/sample_fifo_mem.sv
// Simple dual-port sample RAM: synchronous write, synchronous read-first read port with an
// output register that is cleared by reset.
module sample_fifo_mem #(
  parameter int EW    = 32,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [EW-1:0] wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [EW-1:0] rd_data
);

  logic [EW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // A read of the address being written returns the old contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/sample_fifo.sv
// Single-clock sample FIFO: pointers, fill level, watermarks, sticky error flags and the
// optional first-word-fall-through head register around a sync-read sample RAM.
module sample_fifo
  import sample_fifo_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 2,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = 12,
  parameter int AE_LEVEL = 4,
  parameter int FWFT     = 0,
  localparam int EW      = WIDTH * CHANNELS,
  localparam int LW      = level_width(DEPTH)
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          CLEAR,
  input  logic          WRITE,
  input  logic [EW-1:0] DIN,
  input  logic          READ,
  output logic [EW-1:0] DOUT,
  output logic          DOUT_VALID,
  output logic          FULL,
  output logic          EMPTY,
  output logic          ALMOST_FULL,
  output logic          ALMOST_EMPTY,
  output logic [LW-1:0] LEVEL,
  output logic          OVERFLOW,
  output logic          UNDERFLOW,
  input  logic          CLR_ERR
);

  localparam int AW = LW - 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
  localparam logic [LW-1:0] AF_L    = LW'(AF_LEVEL);
  localparam logic [LW-1:0] AE_L    = LW'(AE_LEVEL);

  if ((DEPTH & (DEPTH - 1)) != 0 || DEPTH < 4 || AE_LEVEL >= AF_LEVEL || AF_LEVEL > DEPTH)
  begin : g_param_check
    $error("sample_fifo: DEPTH must be a power of two >= 4 and AE_LEVEL < AF_LEVEL <= DEPTH");
  end

  logic [LW-1:0] wr_ptr, rd_ptr, rd_ptr_nxt, level_q, level_nxt;
  fifo_status_t  status;
  logic          wr_ok, rd_ok, ovf_evt, unf_evt;
  logic          dv_q, byp_valid, mem_rd_en;
  logic [AW-1:0] mem_rd_addr;
  logic [EW-1:0] byp_data, mem_q;

  // Handshake: WRITE and READ are single-cycle requests sampled on the rising edge. A write is
  // taken when the FIFO is not full or a read is taken in the same cycle; a read is taken when
  // the FIFO is not empty. Refused requests raise the sticky error flags; CLEAR refuses both
  // without raising an error.
  always_comb begin
    rd_ok      = !CLEAR && READ && !status.empty;
    wr_ok      = !CLEAR && WRITE && (!status.full || rd_ok);
    ovf_evt    = !CLEAR && WRITE && !wr_ok;
    unf_evt    = !CLEAR && READ && status.empty;
    rd_ptr_nxt = CLEAR ? '0 : rd_ptr + {{AW{1'b0}}, rd_ok};
    level_nxt  = level_q;
    if (CLEAR)               level_nxt = '0;
    else if (wr_ok && !rd_ok) level_nxt = level_q + {{AW{1'b0}}, 1'b1};
    else if (rd_ok && !wr_ok) level_nxt = level_q - {{AW{1'b0}}, 1'b1};
  end

  // FWFT prefetches the post-edge head every cycle; registered mode reads only on a pop.
  always_comb begin
    if (FWFT != 0) begin
      mem_rd_en   = !CLEAR && (level_nxt != '0);
      mem_rd_addr = rd_ptr_nxt[AW-1:0];
    end else begin
      mem_rd_en   = rd_ok;
      mem_rd_addr = rd_ptr[AW-1:0];
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level_q   <= '0;
      status    <= '{full: 1'b0, empty: 1'b1, almost_full: 1'b0, almost_empty: 1'b1,
                     overflow: 1'b0, underflow: 1'b0};
      dv_q      <= 1'b0;
      byp_valid <= 1'b0;
      byp_data  <= '0;
    end else begin
      wr_ptr                <= CLEAR ? '0 : wr_ptr + {{AW{1'b0}}, wr_ok};
      rd_ptr                <= rd_ptr_nxt;
      level_q               <= level_nxt;
      status.full           <= (level_nxt == DEPTH_L);
      status.empty          <= (level_nxt == '0);
      status.almost_full    <= (level_nxt >= AF_L);
      status.almost_empty   <= (level_nxt <= AE_L);
      status.overflow       <= ovf_evt || (status.overflow && !CLR_ERR);
      status.underflow      <= unf_evt || (status.underflow && !CLR_ERR);
      dv_q                  <= rd_ok;
      // The RAM read port cannot see a same-edge write, so a write landing on the new head
      // is captured here instead.
      if (mem_rd_en) begin
        byp_valid <= (FWFT != 0) && wr_ok && (wr_ptr[AW-1:0] == mem_rd_addr);
        byp_data  <= DIN;
      end
    end
  end

  sample_fifo_mem #(.EW(EW), .DEPTH(DEPTH)) u_mem (
    .clk     (CLK),
    .rst     (RESET),
    .wr_en   (wr_ok),
    .wr_addr (wr_ptr[AW-1:0]),
    .wr_data (DIN),
    .rd_en   (mem_rd_en),
    .rd_addr (mem_rd_addr),
    .rd_data (mem_q)
  );

  assign DOUT         = byp_valid ? byp_data : mem_q;
  assign DOUT_VALID   = (FWFT != 0) ? !status.empty : dv_q;
  assign FULL         = status.full;
  assign EMPTY        = status.empty;
  assign ALMOST_FULL  = status.almost_full;
  assign ALMOST_EMPTY = status.almost_empty;
  assign OVERFLOW     = status.overflow;
  assign UNDERFLOW    = status.underflow;
  assign LEVEL        = level_q;

endmodule

// File: tb/tb_sample_fifo.sv
// Bench for sample_fifo: registered-read and FWFT instances share one stimulus stream and are
// checked every cycle against a queue model, plus fixed-value checks for the directed cases.
module tb_sample_fifo;

  localparam int DEPTH = 16;
  localparam int EW    = 32;
  localparam int LW    = 5;
  localparam int AF    = 12;
  localparam int AE    = 4;

  logic          clk, rst, clear, write, read, clr_err;
  logic [EW-1:0] din;
  logic [EW-1:0] d0_dout, d1_dout;
  logic          d0_dv, d0_full, d0_empty, d0_af, d0_ae, d0_ovf, d0_unf;
  logic          d1_dv, d1_full, d1_empty, d1_af, d1_ae, d1_ovf, d1_unf;
  logic [LW-1:0] d0_level, d1_level;

  int n_vec = 0;
  int n_err = 0;
  bit check_en = 0;

  sample_fifo #(.WIDTH(16), .CHANNELS(2), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(0))
  u_dut (
    .CLK(clk), .RESET(rst), .CLEAR(clear), .WRITE(write), .DIN(din), .READ(read),
    .DOUT(d0_dout), .DOUT_VALID(d0_dv), .FULL(d0_full), .EMPTY(d0_empty),
    .ALMOST_FULL(d0_af), .ALMOST_EMPTY(d0_ae), .LEVEL(d0_level),
    .OVERFLOW(d0_ovf), .UNDERFLOW(d0_unf), .CLR_ERR(clr_err)
  );

  sample_fifo #(.WIDTH(16), .CHANNELS(2), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1))
  u_fwft (
    .CLK(clk), .RESET(rst), .CLEAR(clear), .WRITE(write), .DIN(din), .READ(read),
    .DOUT(d1_dout), .DOUT_VALID(d1_dv), .FULL(d1_full), .EMPTY(d1_empty),
    .ALMOST_FULL(d1_af), .ALMOST_EMPTY(d1_ae), .LEVEL(d1_level),
    .OVERFLOW(d1_ovf), .UNDERFLOW(d1_unf), .CLR_ERR(clr_err)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model ----------------
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] m_dout;
  bit            m_dv, m_ovf, m_unf, r_ok, w_ok;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
      m_dout = '0;
      m_dv   = 0;
      m_ovf  = 0;
      m_unf  = 0;
    end else begin
      r_ok = 0;
      w_ok = 0;
      if (clear) begin
        exp_q.delete();
        m_dv = 0;
      end else begin
        r_ok = read && (exp_q.size() > 0);
        w_ok = write && (exp_q.size() < DEPTH || r_ok);
        m_dv = r_ok;
        if (r_ok) m_dout = exp_q.pop_front();
        if (w_ok) exp_q.push_back(din);
      end
      m_ovf = (!clear && write && !w_ok) ? 1'b1 : (clr_err ? 1'b0 : m_ovf);
      m_unf = (!clear && read && !r_ok) ? 1'b1 : (clr_err ? 1'b0 : m_unf);
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && check_en) begin
      chk("level",   64'(d0_level), 64'(exp_q.size()));
      chk("full",    64'(d0_full),  64'(exp_q.size() == DEPTH));
      chk("empty",   64'(d0_empty), 64'(exp_q.size() == 0));
      chk("a_full",  64'(d0_af),    64'(exp_q.size() >= AF));
      chk("a_empty", 64'(d0_ae),    64'(exp_q.size() <= AE));
      chk("ovf",     64'(d0_ovf),   64'(m_ovf));
      chk("unf",     64'(d0_unf),   64'(m_unf));
      chk("dv",      64'(d0_dv),    64'(m_dv));
      chk("dout",    64'(d0_dout),  64'(m_dout));
      chk("f_level", 64'(d1_level), 64'(exp_q.size()));
      chk("f_full",  64'(d1_full),  64'(exp_q.size() == DEPTH));
      chk("f_empty", 64'(d1_empty), 64'(exp_q.size() == 0));
      chk("f_afull", 64'(d1_af),    64'(exp_q.size() >= AF));
      chk("f_aempt", 64'(d1_ae),    64'(exp_q.size() <= AE));
      chk("f_ovf",   64'(d1_ovf),   64'(m_ovf));
      chk("f_unf",   64'(d1_unf),   64'(m_unf));
      chk("f_dv",    64'(d1_dv),    64'(exp_q.size() != 0));
      if (exp_q.size() != 0) chk("f_dout", 64'(d1_dout), 64'(exp_q[0]));
    end
  end

  // ---------------- driver ----------------
  task automatic cyc(input bit w, input logic [EW-1:0] d, input bit r,
                     input bit c = 1'b0, input bit ce = 1'b0);
    write   = w;
    din     = d;
    read    = r;
    clear   = c;
    clr_err = ce;
    @(negedge clk);
    write   = 1'b0;
    read    = 1'b0;
    clear   = 1'b0;
    clr_err = 1'b0;
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    rst = 1'b1; clear = 0; write = 0; read = 0; clr_err = 0; din = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_en = 1;

    chk("rst_level", 64'(d0_level), 0);
    chk("rst_empty", 64'(d0_empty), 1);
    chk("rst_aempt", 64'(d0_ae), 1);
    chk("rst_full",  64'(d0_full), 0);
    chk("rst_dout",  64'(d0_dout), 0);

    // Fill to full, then one write too many.
    for (int k = 1; k <= 16; k++) begin
      cyc(1, k * 32'h0001_0001, 0);
      if (k == 11) chk("af_at_11", 64'(d0_af), 0);
      if (k == 12) chk("af_at_12", 64'(d0_af), 1);
    end
    chk("t1_full",  64'(d0_full), 1);
    chk("t1_level", 64'(d0_level), 16);
    cyc(1, 32'hDEAD_0000, 0);
    chk("t1_ovf",   64'(d0_ovf), 1);
    chk("t1_lvl17", 64'(d0_level), 16);

    // Drain in order, then one read too many.
    for (int k = 1; k <= 16; k++) begin
      cyc(0, '0, 1);
      chk("t2_dv",   64'(d0_dv), 1);
      chk("t2_dout", 64'(d0_dout), 64'(k * 32'h0001_0001));
    end
    chk("t2_empty", 64'(d0_empty), 1);
    cyc(0, '0, 1);
    chk("t2_unf",   64'(d0_unf), 1);
    chk("t2_hold",  64'(d0_dout), 64'h0010_0010);
    chk("t2_nodv",  64'(d0_dv), 0);
    cyc(0, '0, 0, 0, 1);
    chk("clr_ovf",  64'(d0_ovf), 0);
    chk("clr_unf",  64'(d0_unf), 0);

    // Full FIFO with simultaneous read and write across the pointer wrap.
    for (int k = 0; k < 16; k++) cyc(1, $urandom, 0);
    for (int k = 0; k < 40; k++) cyc(1, $urandom, 1);
    chk("t3_level", 64'(d0_level), 16);
    chk("t3_ovf",   64'(d0_ovf), 0);
    cyc(0, '0, 0, 1);
    chk("clr_level", 64'(d0_level), 0);

    // Empty FIFO, read and write together: write lands, read refused.
    cyc(1, 32'hBEEF_CAFE, 1);
    chk("t4_unf",   64'(d0_unf), 1);
    chk("t4_level", 64'(d0_level), 1);
    cyc(0, '0, 1);
    chk("t4_dout",  64'(d0_dout), 64'hBEEF_CAFE);
    chk("t4_dv",    64'(d0_dv), 1);
    cyc(0, '0, 0, 0, 1);

    // First-word-fall-through view.
    cyc(1, 32'h1234_5678, 0);
    chk("t5_fdout", 64'(d1_dout), 64'h1234_5678);
    chk("t5_fdv",   64'(d1_dv), 1);
    cyc(0, '0, 1);
    chk("t5_fempty", 64'(d1_empty), 1);

    // Asynchronous reset in the middle of a cycle.
    for (int k = 0; k < 7; k++) cyc(1, $urandom, 0);
    chk("t6_level7", 64'(d0_level), 7);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t6_level", 64'(d0_level), 0);
    chk("t6_empty", 64'(d0_empty), 1);
    chk("t6_aempt", 64'(d0_ae), 1);
    chk("t6_afull", 64'(d0_af), 0);
    chk("t6_dout",  64'(d0_dout), 0);
    chk("t6_flvl",  64'(d1_level), 0);
    chk("t6_fdv",   64'(d1_dv), 0);
    @(negedge clk);
    rst = 1'b0;

    // CLEAR beats a same-cycle write and leaves the error flags alone.
    cyc(0, '0, 1);
    cyc(1, 32'hAAAA_5555, 0, 1);
    chk("t6_clr_lvl", 64'(d0_level), 0);
    chk("t6_clr_unf", 64'(d0_unf), 1);
    chk("t6_clr_ovf", 64'(d0_ovf), 0);

    // Random traffic with fill-biased, drain-biased and balanced phases.
    for (int i = 0; i < 2000; i++) begin
      int ph;
      int wp;
      int rp;
      ph = (i / 200) % 3;
      wp = (ph == 0) ? 75 : (ph == 1) ? 30 : 50;
      rp = (ph == 0) ? 30 : (ph == 1) ? 75 : 50;
      cyc($urandom_range(0, 99) < wp, $urandom, $urandom_range(0, 99) < rp,
          $urandom_range(0, 99) == 0, $urandom_range(0, 15) == 0);
    end

    check_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
